segment_mem_responder: RTL and testbench



---
 rtl/segment_pkg.sv | 20 ++
 rtl/segment_mem_responder_if.sv | 24 ++
 rtl/segment_word_ram.sv | 20 ++
 rtl/segment_mem_responder.sv | 112 +++++++++++
 tb/tb_segment_mem_responder.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/segment_pkg.sv
// Shared definitions for the segment memory responder: FSM encoding,
// counter width and the read-latency bound.
package segment_pkg;

    localparam int COUNT_W          = 16;
    localparam int MAX_READ_LATENCY = 15;
    localparam int LAT_W            = $clog2(MAX_READ_LATENCY + 1);

    typedef logic [2:0] state_t;
    localparam state_t ST_IDLE       = 3'd0;
    localparam state_t ST_RD_LAT     = 3'd1;
    localparam state_t ST_RD_DONE    = 3'd2;
    localparam state_t ST_WR_ACK     = 3'd3;
    localparam state_t ST_WR_RELEASE = 3'd4;

    function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/segment_mem_responder_if.sv
// SDRAM request/response handshake between the segment engine (master)
// and a memory responder (slave).
interface segment_mem_responder_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 64
);
    logic                  i_sdram_read;
    logic                  i_sdram_write;
    logic [ADDR_WIDTH-1:0] i_sdram_address;
    logic [DATA_WIDTH-1:0] i_sdram_writedata;
    logic                  o_sdram_waitrequest;
    logic                  o_sdram_readdatavalid;
    logic [DATA_WIDTH-1:0] o_sdram_readdata;

    modport master (
        output i_sdram_read, i_sdram_write, i_sdram_address, i_sdram_writedata,
        input  o_sdram_waitrequest, o_sdram_readdatavalid, o_sdram_readdata
    );

    modport slave (
        input  i_sdram_read, i_sdram_write, i_sdram_address, i_sdram_writedata,
        output o_sdram_waitrequest, o_sdram_readdatavalid, o_sdram_readdata
    );
endinterface

// File: rtl/segment_word_ram.sv
// Simple dual-port word array: one write port, one registered read port.
// No reset so it maps onto block RAM; contents survive the responder reset.
module segment_word_ram #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);
    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

    always_ff @(posedge clk) begin
        if (we) mem[wr_addr] <= wr_data;
        rd_data <= mem[rd_addr];
    end
endmodule

// File: rtl/segment_mem_responder.sv
// On-chip stand-in for the SDRAM controller: single-word reads/writes with
// "waitrequest-high means accepted" handshake and programmable read latency.
module segment_mem_responder
    import segment_pkg::*;
#(
    parameter int ADDR_WIDTH   = 8,
    parameter int DATA_WIDTH   = 64,
    parameter int READ_LATENCY = 3
) (
    input  logic               clk,
    input  logic               reset,
    segment_mem_responder_if.slave bus,
    output logic               o_busy,
    output logic               o_protocol_error,
    output logic [COUNT_W-1:0] o_rd_count,
    output logic [COUNT_W-1:0] o_wr_count
);
    state_t                state, next_state;
    logic [LAT_W-1:0]      lat_cnt;
    logic [ADDR_WIDTH-1:0] addr_q, rd_addr;
    logic                  wait_q, rdv_q, perr_q;
    logic                  wait_d, rdv_d, perr_d;
    logic                  ram_we;
    logic [DATA_WIDTH-1:0] ram_q;

    wire idle = (state == ST_IDLE);
    wire rd   = bus.i_sdram_read;
    wire wr   = bus.i_sdram_write;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= next_state;
    end

    // Next-state logic; write wins when both requests are high in IDLE
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: begin
                if (wr)      next_state = ST_WR_ACK;
                else if (rd) next_state = (READ_LATENCY == 1) ? ST_RD_DONE : ST_RD_LAT;
            end
            ST_RD_LAT:     if (lat_cnt == LAT_W'(2)) next_state = ST_RD_DONE;
            ST_RD_DONE:    next_state = ST_IDLE;
            ST_WR_ACK:     next_state = ST_WR_RELEASE;
            ST_WR_RELEASE: if (!wr) next_state = ST_IDLE;
            default:       next_state = ST_IDLE;
        endcase
    end

    // Output logic computed from the next state so the handshake is registered
    always_comb begin
        wait_d = 1'b0;
        rdv_d  = 1'b0;
        perr_d = idle && rd && wr;
        case (next_state)
            ST_RD_LAT:  wait_d = 1'b1;
            ST_RD_DONE: begin
                wait_d = 1'b1;
                rdv_d  = 1'b1;
            end
            ST_WR_ACK:  wait_d = 1'b1;
            default:    ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_q     <= 1'b0;
            rdv_q      <= 1'b0;
            perr_q     <= 1'b0;
            lat_cnt    <= '0;
            addr_q     <= '0;
            o_rd_count <= '0;
            o_wr_count <= '0;
        end else begin
            wait_q <= wait_d;
            rdv_q  <= rdv_d;
            perr_q <= perr_d;
            if (idle && (rd || wr)) addr_q <= bus.i_sdram_address;
            if (idle && rd && !wr)        lat_cnt <= LAT_W'(READ_LATENCY);
            else if (state == ST_RD_LAT)  lat_cnt <= lat_cnt - 1'b1;
            if (state == ST_RD_DONE) o_rd_count <= sat_inc(o_rd_count);
            if (state == ST_WR_ACK)  o_wr_count <= sat_inc(o_wr_count);
        end
    end

    // In IDLE the RAM looks up the incoming address so a latency-1 read has
    // data ready on the very next cycle; afterwards it re-reads the latched one.
    assign rd_addr = idle ? bus.i_sdram_address : addr_q;
    assign ram_we  = idle && wr;

    segment_word_ram #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_ram (
        .clk     (clk),
        .we      (ram_we),
        .wr_addr (bus.i_sdram_address),
        .wr_data (bus.i_sdram_writedata),
        .rd_addr (rd_addr),
        .rd_data (ram_q)
    );

    // The RAM output register has no reset; gate it so readdata is 0 outside the strobe
    assign bus.o_sdram_readdata      = rdv_q ? ram_q : '0;
    assign bus.o_sdram_waitrequest   = wait_q;
    assign bus.o_sdram_readdatavalid = rdv_q;
    assign o_busy                    = !idle;
    assign o_protocol_error          = perr_q;
endmodule

// File: tb/tb_segment_mem_responder.sv
// Directed bench: one responder at read latency 3, one at latency 1, with
// engine-style handshakes and a read-data scoreboard per instance.
module tb_segment_mem_responder;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic        rd [2];
    logic        wr [2];
    logic [7:0]  ad [2];
    logic [63:0] wd [2];
    logic        wq [2];
    logic        rv [2];
    logic [63:0] rdat [2];
    logic        busy [2];
    logic        perr [2];
    logic [15:0] rc [2];
    logic [15:0] wc [2];

    int errors = 0;
    int checks = 0;

    logic [63:0] model0 [256];
    logic [63:0] model1 [256];
    logic [63:0] exp_q0 [$];
    logic [63:0] exp_q1 [$];
    logic [15:0] exp_rc [2];
    logic [15:0] exp_wc [2];

    segment_mem_responder_if #(.ADDR_WIDTH(8), .DATA_WIDTH(64)) if_a ();
    segment_mem_responder_if #(.ADDR_WIDTH(8), .DATA_WIDTH(64)) if_b ();

    assign if_a.i_sdram_read      = rd[0];
    assign if_a.i_sdram_write     = wr[0];
    assign if_a.i_sdram_address   = ad[0];
    assign if_a.i_sdram_writedata = wd[0];
    assign wq[0]   = if_a.o_sdram_waitrequest;
    assign rv[0]   = if_a.o_sdram_readdatavalid;
    assign rdat[0] = if_a.o_sdram_readdata;

    assign if_b.i_sdram_read      = rd[1];
    assign if_b.i_sdram_write     = wr[1];
    assign if_b.i_sdram_address   = ad[1];
    assign if_b.i_sdram_writedata = wd[1];
    assign wq[1]   = if_b.o_sdram_waitrequest;
    assign rv[1]   = if_b.o_sdram_readdatavalid;
    assign rdat[1] = if_b.o_sdram_readdata;

    segment_mem_responder #(.ADDR_WIDTH(8), .DATA_WIDTH(64), .READ_LATENCY(3)) dut_a (
        .clk(clk), .reset(reset), .bus(if_a.slave),
        .o_busy(busy[0]), .o_protocol_error(perr[0]),
        .o_rd_count(rc[0]), .o_wr_count(wc[0])
    );

    segment_mem_responder #(.ADDR_WIDTH(8), .DATA_WIDTH(64), .READ_LATENCY(1)) dut_b (
        .clk(clk), .reset(reset), .bus(if_b.slave),
        .o_busy(busy[1]), .o_protocol_error(perr[1]),
        .o_rd_count(rc[1]), .o_wr_count(wc[1])
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Scoreboards: every readdatavalid strobe must match the oldest expectation
    always @(negedge clk) begin
        if (rv[0] === 1'b1) begin
            if (exp_q0.size() > 0) chk("rd_data_a", rdat[0], exp_q0.pop_front());
            else                   chk("rdv_spurious_a", 64'(rv[0]), 64'd0);
        end
    end
    always @(negedge clk) begin
        if (rv[1] === 1'b1) begin
            if (exp_q1.size() > 0) chk("rd_data_b", rdat[1], exp_q1.pop_front());
            else                   chk("rdv_spurious_b", 64'(rv[1]), 64'd0);
        end
    end

    function automatic int lat_of(input int s);
        return (s == 0) ? 3 : 1;
    endfunction

    function automatic logic [15:0] sat(input logic [15:0] v);
        return (&v) ? v : v + 16'd1;
    endfunction

    task automatic do_write(input int s, input logic [7:0] a, input logic [63:0] d,
                            input bit also_read);
        int n;
        @(negedge clk);
        wr[s] = 1'b1; rd[s] = also_read; ad[s] = a; wd[s] = d;
        n = 0;
        do begin @(negedge clk); n++; end while (wq[s] !== 1'b1 && n < 20);
        chk("wr_accept", 64'(wq[s]), 64'd1);
        if (wq[s] !== 1'b1) begin wr[s] = 1'b0; rd[s] = 1'b0; return; end
        if (s == 0) model0[a] = d; else model1[a] = d;
        chk("wr_busy", 64'(busy[s]), 64'd1);
        chk("wr_protocol_error", 64'(perr[s]), 64'(also_read));
        // engine keeps the request up for the cycle after waitrequest rises
        @(negedge clk);
        exp_wc[s] = sat(exp_wc[s]);
        chk("wr_wait_one_cycle", 64'(wq[s]), 64'd0);
        chk("wr_count", 64'(wc[s]), 64'(exp_wc[s]));
        chk("perr_one_pulse", 64'(perr[s]), 64'd0);
        wr[s] = 1'b0; rd[s] = 1'b0;
        @(negedge clk);
        chk("wr_back_to_idle", 64'(busy[s]), 64'd0);
        chk("wr_no_rdv", 64'(rv[s]), 64'd0);
    endtask

    task automatic do_read(input int s, input logic [7:0] a);
        int n;
        int lat;
        lat = lat_of(s);
        @(negedge clk);
        rd[s] = 1'b1; wr[s] = 1'b0; ad[s] = a;
        if (s == 0) exp_q0.push_back(model0[a]); else exp_q1.push_back(model1[a]);
        n = 0;
        do begin @(negedge clk); n++; end while (wq[s] !== 1'b1 && n < 20);
        chk("rd_accept", 64'(wq[s]), 64'd1);
        if (wq[s] !== 1'b1) begin rd[s] = 1'b0; return; end
        for (int i = 1; i <= lat; i++) begin
            if (i > 1) @(negedge clk);
            if (i == 2) rd[s] = 1'b0;
            chk("rd_wait_window", 64'(wq[s]), 64'd1);
            chk("rd_valid_window", 64'(rv[s]), 64'(i == lat));
        end
        @(negedge clk);
        rd[s] = 1'b0;
        exp_rc[s] = sat(exp_rc[s]);
        chk("rd_wait_drop", 64'(wq[s]), 64'd0);
        chk("rd_valid_drop", 64'(rv[s]), 64'd0);
        chk("rd_count", 64'(rc[s]), 64'(exp_rc[s]));
    endtask

    initial begin
        logic [63:0] d;
        for (int s = 0; s < 2; s++) begin
            rd[s] = 1'b0; wr[s] = 1'b0; ad[s] = '0; wd[s] = '0;
            exp_rc[s] = '0; exp_wc[s] = '0;
        end
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            chk("reset_wait", 64'(wq[s]), 64'd0);
            chk("reset_rdv", 64'(rv[s]), 64'd0);
            chk("reset_rdata", rdat[s], 64'd0);
            chk("reset_busy", 64'(busy[s]), 64'd0);
            chk("reset_perr", 64'(perr[s]), 64'd0);
            chk("reset_rc", 64'(rc[s]), 64'd0);
            chk("reset_wc", 64'(wc[s]), 64'd0);
        end

        // basic write then latency-3 read
        do_write(0, 8'd5, 64'hDEAD_BEEF_0000_0001, 1'b0);
        do_read(0, 8'd5);

        // latency-1 instance: write address 0, then read it back
        do_write(1, 8'd0, 64'h0123_4567_89AB_CDEF, 1'b0);
        do_read(1, 8'd0);

        // read and write together: write wins, error pulses, no read data
        do_write(0, 8'd7, 64'hCAFE_F00D_7777_0007, 1'b1);
        do_read(0, 8'd7);

        // engine-style write/read fragment pairs
        for (int i = 0; i < 5; i++) begin
            d = {$urandom, $urandom};
            do_write(0, 8'(i), d, 1'b0);
            do_read(0, 8'(i));
        end
        chk("pairs_rd_count", 64'(rc[0]), 64'd7);
        chk("pairs_wr_count", 64'(wc[0]), 64'd7);

        // reset in the middle of a read latency countdown
        @(negedge clk);
        rd[0] = 1'b1; ad[0] = 8'd5;
        @(negedge clk);
        chk("pre_reset_wait", 64'(wq[0]), 64'd1);
        #2 reset = 1'b1;
        #1;
        chk("async_reset_wait", 64'(wq[0]), 64'd0);
        chk("async_reset_busy", 64'(busy[0]), 64'd0);
        chk("async_reset_rc", 64'(rc[0]), 64'd0);
        chk("async_reset_wc", 64'(wc[0]), 64'd0);
        rd[0] = 1'b0;
        exp_rc[0] = '0; exp_wc[0] = '0; exp_rc[1] = '0; exp_wc[1] = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        chk("post_reset_idle", 64'(busy[0]), 64'd0);
        do_read(0, 8'd5);
        do_read(1, 8'd0);

        repeat (2) @(negedge clk);
        chk("scoreboard_a_drained", 64'(exp_q0.size()), 64'd0);
        chk("scoreboard_b_drained", 64'(exp_q1.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
